// File: rtl/rst_sequencer_n.sv
// Cumulative active-low reset sequencer: releases N_STAGES lines one per step, each step dwelling DWELL[k] ticks.
// Define RST_SEQ_PRESCALE_EN to count dwell in PRESCALE-clock ticks instead of single clocks.
module rst_sequencer_n #(
   parameter int                        N_STAGES   = 5,
   parameter int                        CNT_W      = 32,
   parameter logic [N_STAGES*CNT_W-1:0] DWELL      = {N_STAGES{CNT_W'(100_000_000)}},
   parameter bit                        AUTO_START = 1'b1,
   parameter int                        PRESCALE   = 1,
   localparam int                       STEP_W     = $clog2(N_STAGES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                hold,
   input  logic                restart,
   output logic [N_STAGES-1:0] stage_n,
   output logic [STEP_W-1:0]   step,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [STEP_W-1:0]   step_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [CNT_W-1:0]    dwell_m1;
   logic [N_STAGES-1:0] stage_n_d;
   logic                busy_d;
   logic                done_d;
   logic                tick;

`ifdef RST_SEQ_PRESCALE_EN
   localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [DIV_W-1:0] div_q;

   assign tick = (div_q == DIV_W'(PRESCALE - 1));

   // Every step change happens on a tick, so wrapping at the tick also clears the divider per step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
      end else if (restart || state_q != S_RUN) begin
         div_q <= '0;
      end else if (!hold) begin
         div_q <= tick ? '0 : div_q + 1'b1;
      end
   end
`else
   assign tick = 1'b1 | (PRESCALE != 0);
`endif

   // A zero dwell behaves as one tick, so the terminal count saturates at zero.
   always_comb begin
      dwell_m1 = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         if (step == STEP_W'(k)) begin
            dwell_m1 = (DWELL[k*CNT_W +: CNT_W] == '0) ? '0 : DWELL[k*CNT_W +: CNT_W] - 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step;
      cnt_d   = cnt_q;
      if (restart) begin
         state_d = S_IDLE;
         step_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               step_d = '0;
               cnt_d  = '0;
               if (AUTO_START || start) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (!hold && tick) begin
                  if (cnt_q == dwell_m1) begin
                     cnt_d  = '0;
                     step_d = step + 1'b1;
                     if (step == STEP_W'(N_STAGES - 1)) begin
                        state_d = S_DONE;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs are decoded from the next state so they register on the same edge as the step.
      stage_n_d = '1;
      for (int i = 0; i < N_STAGES; i++) begin
         stage_n_d[i] = (i >= int'(step_d));
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         step    <= '0;
         cnt_q   <= '0;
         stage_n <= '1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         step    <= step_d;
         cnt_q   <= cnt_d;
         stage_n <= stage_n_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: doc/rst_sequencer_n.md
Name: rst_sequencer_n

Overview:
- Parametrised successor to the fixed five-stage reset sequencer.
- Drives N_STAGES active-low stage-control lines that are released cumulatively, one stage per step, with a per-step dwell time taken from a packed parameter vector.
- Adds a start handshake, hold and restart controls, and status outputs (step, busy, done).
- Sits at the top level and sequences mem, PE, array and display sub-blocks.

Parameters:
- N_STAGES, 5: number of stage-control outputs (1..16).
- CNT_W, 32: dwell counter width.
- DWELL, {5{32'd100_000_000}}: packed N_STAGES*CNT_W. Slice k, bits [k*CNT_W +: CNT_W], is the length of step k in counted ticks. A value of 0 is treated as 1.
- AUTO_START, 1: 1 = leave IDLE immediately after reset; 0 = wait for start.
- PRESCALE, 1: ticks per dwell count. Used only when PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin the sequence. Sampled only in IDLE.
- hold  in  1  while high, freezes the dwell counter and the step.
- restart  in  1  synchronous return to IDLE with all outputs high.
- stage_n  out  N_STAGES  stage-control lines, active-low, cumulative.
- step  out  $clog2(N_STAGES+1)  current step index, 0..N_STAGES.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, step=0, counter=0.
  - stage_n = all ones, busy=0, done=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - stage_n = all ones.
  - Goes to RUN with step=0, counter=0 on the cycle after start=1.
  - With AUTO_START=1, goes to RUN on the first clock after reset release.
- RUN, in step k (0..N_STAGES-1):
  - stage_n[i]=0 for i<k, 1 otherwise.
  - counter increments on each tick while hold=0.
  - When counter reaches max(DWELL[k],1)-1 on a tick: counter clears and step becomes k+1.
  - Step k therefore lasts exactly max(DWELL[k],1) ticks.
  - When step becomes N_STAGES, state goes to DONE.
- DONE:
  - stage_n = all zeros, step=N_STAGES, done=1.
  - Held indefinitely; leaves only on restart or reset.
- Output timing:
  - stage_n, step, busy and done all change on the same clock edge as the state/step update.
  - No combinational path from the inputs to any output.
- hold:
  - Counter and step are frozen; stage_n is unchanged.
  - No effect in IDLE or DONE.
  - hold and expiry in the same cycle: hold wins, no advance.
- restart:
  - Highest synchronous priority.
  - Next cycle: state=IDLE, step=0, counter=0, stage_n all ones.
  - Overrides hold, start and a pending expiry in the same cycle.
  - With AUTO_START=1, IDLE re-enters RUN on the following cycle.
- start outside IDLE is ignored.
- Counter arithmetic:
  - Unsigned CNT_W bits; the comparison uses the dwell value minus 1.
  - The counter never wraps, because it clears on expiry.
- DWELL slice ordering: LSB slice = step 0.

Optional Feature:
- Macro: RST_SEQ_PRESCALE_EN.
- Defined:
  - An internal PRESCALE-cycle divider generates a one-cycle tick.
  - The dwell counter advances only on tick, so a dwell of D lasts D*PRESCALE clocks.
  - The divider clears on reset, restart and each step change.
  - The divider is frozen by hold.
- Undefined:
  - tick is constant 1, so one count per clock.
  - PRESCALE is ignored and no divider logic is generated.

Test Plan:
1. N_STAGES=5, DWELL={5,4,3,2,1} (step0=1…step4=5), AUTO_START=1; release reset.
   -> stage_n = 11111 for 1 clk, 11110 for 2, 11100 for 3, 11000 for 4, 10000 for 5, then 00000.
   -> done=1, step=5 remains stable for 100 clks.
2. AUTO_START=0, DWELL all 3.
   -> stage_n stays 11111 and busy=0 for 50 clks without start.
   -> one-cycle start pulse: busy=1 next cycle; done exactly 15 clks after busy rises.
3. DWELL all 4; assert hold for 6 clks in the middle of step 2.
   -> step stays 2 and stage_n stays 11100 during hold.
   -> total time to done = 20+6 clks.
4. restart in step 3, and again in DONE.
   -> next cycle stage_n=11111, step=0, done=0.
   -> with AUTO_START=1, busy returns the cycle after.
5. Assert rst low mid-step 2 for a fraction of a clock period.
   -> outputs go to all ones immediately (asynchronous).
   -> on release, the sequence replays from step 0.
6. With RST_SEQ_PRESCALE_EN defined, PRESCALE=4, DWELL all 2.
   -> each step lasts 8 clks; done after 40 clks.
   -> hold asserted mid-divide extends the step by exactly the hold length.
